// File: rtl/column_packer_if.sv
// Pixel-in / column-word-out FIFO handshake bundle for the Sobel front end.
// master = packer side, slave = FIFO/environment side.
interface column_packer_if #(
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
);
  logic                  fifo_in_rd_en;
  logic [DWIDTH_IN-1:0]  fifo_in_dout;
  logic                  fifo_in_empty;
  logic                  fifo_out_wr_en;
  logic [DWIDTH_OUT-1:0] fifo_out_din;
  logic                  fifo_out_full;
  logic                  frame_done;

  modport master (
    output fifo_in_rd_en, fifo_out_wr_en, fifo_out_din, frame_done,
    input  fifo_in_dout, fifo_in_empty, fifo_out_full
  );

  modport slave (
    input  fifo_in_rd_en, fifo_out_wr_en, fifo_out_din, frame_done,
    output fifo_in_dout, fifo_in_empty, fifo_out_full
  );
endinterface

// File: rtl/column_packer.sv
// Streams grayscale pixels into 3-row column words {row y, row y-1, row y-2}
// using two line buffers and a single output holding register.
module column_packer #(
  parameter int WIDTH      = 720,
  parameter int HEIGHT     = 540,
  parameter int DWIDTH_IN  = 8,
  parameter int DWIDTH_OUT = 24
) (
  input  logic               clock,
  input  logic               reset,
  column_packer_if.master    io
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic {FILL, STREAM} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  valid_q, valid_d;
  logic [DWIDTH_OUT-1:0] dout_q, dout_d;
  logic                  frame_done_q, frame_done_d;

  // Line buffers carry no reset: the two FILL rows overwrite every entry first.
  logic [DWIDTH_IN-1:0]  lb_old [WIDTH];
  logic [DWIDTH_IN-1:0]  lb_mid [WIDTH];

  logic                  pop, wr, last_col, last_row;
  logic [DWIDTH_IN-1:0]  mid_px, old_px;
  logic [DWIDTH_OUT-1:0] word;

  always_comb begin
    pop          = !reset && !io.fifo_in_empty && (!valid_q || !io.fifo_out_full);
    wr           = !reset && valid_q && !io.fifo_out_full;
    last_col     = (x_q == XW'(WIDTH - 1));
    last_row     = (y_q == YW'(HEIGHT - 1));
    mid_px       = lb_mid[x_q];
    old_px       = lb_old[x_q];
    word         = {io.fifo_in_dout, mid_px, old_px};
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    valid_d      = valid_q;
    dout_d       = dout_q;
    frame_done_d = 1'b0;

    if (pop) begin
      x_d = last_col ? '0 : x_q + 1'b1;
      if (last_col) y_d = last_row ? '0 : y_q + 1'b1;
      frame_done_d = last_col && last_row;
      case (state_q)
        FILL:    if (last_col && y_q == YW'(1)) state_d = STREAM;
        STREAM:  if (last_col && last_row)      state_d = FILL;
        default: state_d = FILL;
      endcase
    end

    // A STREAM pop refills the holder even when it drains this same cycle.
    if (pop && state_q == STREAM) begin
      valid_d = 1'b1;
      dout_d  = word;
    end else if (wr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= FILL;
      x_q          <= '0;
      y_q          <= '0;
      valid_q      <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      valid_q      <= valid_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (pop) begin
      lb_old[x_q] <= mid_px;
      lb_mid[x_q] <= io.fifo_in_dout;
    end
  end

  assign io.fifo_in_rd_en  = pop;
  assign io.fifo_out_wr_en = wr;
  assign io.fifo_out_din   = dout_q;
  assign io.frame_done     = frame_done_q;
endmodule

// File: tb/tb_column_packer.sv
// Bench for column_packer on a 4x4 frame: FIFO models, table of expected
// column words feeding a scoreboard, plus stall / starve / multi-frame / reset cases.
module tb_column_packer;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [7:0]  pix;
    logic        has_word;
    logic [23:0] word;
  } vec_t;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } pix_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  column_packer_if #(.DWIDTH_IN(8), .DWIDTH_OUT(24)) io ();

  column_packer #(.WIDTH(W), .HEIGHT(H), .DWIDTH_IN(8), .DWIDTH_OUT(24)) dut (
    .clock (clock),
    .reset (reset),
    .io    (io.master)
  );

  always #5 clock = ~clock;

  vec_t        tbl [W*H];
  pix_t        pq [$];
  logic [23:0] eq [$];

  int total = 0;
  int bad   = 0;
  int writes, fdones, pops;
  logic        pop_s, fd_pending, rst_prev;
  logic        full_force, force_empty, toggle_empty;
  logic        in_stall, stall_first;
  logic [23:0] held, first2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    force_empty           = toggle_empty ? !force_empty : 1'b0;
    io.fifo_in_empty      = force_empty || (pq.size() == 0);
    io.fifo_in_dout       = (pq.size() != 0) ? pq[0].pix : 8'h00;
    io.fifo_out_full      = full_force;
  endtask

  // Sampled at negedge, well away from the active edge.
  task automatic check();
    if (reset) begin
      chk("rd_en_in_reset", {31'b0, io.fifo_in_rd_en}, 0);
      chk("wr_en_in_reset", {31'b0, io.fifo_out_wr_en}, 0);
      pop_s      = 1'b0;
      fd_pending = 1'b0;
    end else begin
      if (rst_prev) chk("din_after_reset", {8'b0, io.fifo_out_din}, 0);
      chk("frame_done", {31'b0, io.frame_done}, {31'b0, fd_pending});
      if (io.frame_done) fdones++;
      if (io.fifo_out_full) chk("wr_while_full", {31'b0, io.fifo_out_wr_en}, 0);
      if (io.fifo_in_empty) chk("rd_while_empty", {31'b0, io.fifo_in_rd_en}, 0);
      if (io.fifo_out_wr_en) begin
        writes++;
        if (writes == 9) first2 = io.fifo_out_din;
        if (eq.size() == 0) chk("spurious_write", {8'b0, io.fifo_out_din}, 32'hdead_beef);
        else chk("word", {8'b0, io.fifo_out_din}, {8'b0, eq.pop_front()});
      end
      if (in_stall) begin
        if (stall_first) held = io.fifo_out_din;
        stall_first = 1'b0;
        chk("stall_wr_en", {31'b0, io.fifo_out_wr_en}, 0);
        chk("stall_rd_en", {31'b0, io.fifo_in_rd_en}, 0);
        chk("stall_din",   {8'b0, io.fifo_out_din}, {8'b0, held});
      end
      if (io.fifo_in_rd_en && pq.size() == 0) chk("pop_from_empty", 1, 0);
      fd_pending = io.fifo_in_rd_en && (pq.size() != 0) && pq[0].last;
      pop_s      = io.fifo_in_rd_en && (pq.size() != 0);
    end
    rst_prev = reset;
  endtask

  task automatic cycle();
    @(negedge clock);
    check();
    @(posedge clock);
    #1;
    if (pop_s) begin
      void'(pq.pop_front());
      pops++;
    end
    drive();
  endtask

  task automatic push_frame(input logic [7:0] off);
    for (int i = 0; i < W*H; i++) begin
      pq.push_back('{pix: tbl[i].pix + off, last: (i == W*H-1)});
      if (tbl[i].has_word) eq.push_back(tbl[i].word + {off, off, off});
    end
    drive();
  endtask

  task automatic run_idle(input string name, input int budget);
    int n = 0;
    while ((pq.size() != 0 || eq.size() != 0 || fd_pending) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) chk({name, "_timeout"}, n, 0);
  endtask

  task automatic start_test();
    writes = 0;
    fdones = 0;
    pops   = 0;
  endtask

  initial begin
    logic [23:0] wtab [8];
    wtab = '{24'h201000, 24'h211101, 24'h221202, 24'h231303,
             24'h302010, 24'h312111, 24'h322212, 24'h332313};
    for (int i = 0; i < W*H; i++) begin
      tbl[i].pix      = 8'(16 * (i / W) + (i % W));
      tbl[i].has_word = (i >= 2*W);
      tbl[i].word     = (i >= 2*W) ? wtab[i - 2*W] : 24'h0;
    end

    full_force = 0; force_empty = 0; toggle_empty = 0;
    in_stall = 0; stall_first = 0; fd_pending = 0; pop_s = 0; rst_prev = 0;
    held = 0; first2 = 0;
    start_test();
    drive();

    // reset state, with input data already present
    push_frame(8'h00);
    cycle();
    cycle();
    reset = 1'b0;
    drive();

    // single frame, free flowing
    start_test();
    run_idle("frame1", 200);
    chk("frame1_words", writes, 8);
    chk("frame1_done",  fdones, 1);

    // output stall of 5 cycles while the holder is full
    start_test();
    push_frame(8'h00);
    begin
      int n = 0;
      while (writes < 2 && n < 100) begin cycle(); n++; end
      if (n >= 100) chk("stall_wait_timeout", n, 0);
    end
    full_force  = 1'b1;
    in_stall    = 1'b1;
    stall_first = 1'b1;
    drive();
    repeat (5) cycle();
    in_stall   = 1'b0;
    full_force = 1'b0;
    drive();
    run_idle("stall", 200);
    chk("stall_words", writes, 8);
    chk("stall_done",  fdones, 1);

    // input starving every other cycle
    start_test();
    toggle_empty = 1'b1;
    push_frame(8'h00);
    run_idle("starve", 400);
    toggle_empty = 1'b0;
    drive();
    chk("starve_words", writes, 8);
    chk("starve_done",  fdones, 1);

    // back-to-back frames, second offset by 0x80
    start_test();
    push_frame(8'h00);
    push_frame(8'h80);
    run_idle("two_frames", 400);
    chk("two_frames_words", writes, 16);
    chk("two_frames_done",  fdones, 2);
    chk("frame2_first_word", {8'b0, first2}, 32'h00A09080);

    // reset after 10 pops, then a clean frame
    start_test();
    push_frame(8'h00);
    begin
      int n = 0;
      while (pops < 10 && n < 100) begin cycle(); n++; end
      if (n >= 100) chk("mid_reset_wait_timeout", n, 0);
    end
    reset = 1'b1;
    pq.delete();
    eq.delete();
    drive();
    cycle();
    reset = 1'b0;
    start_test();
    push_frame(8'h00);
    run_idle("after_reset", 200);
    chk("after_reset_words", writes, 8);
    chk("after_reset_done",  fdones, 1);

    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
